// File: rtl/lc3b_word_cache.sv
// lc3b_word_cache: direct-mapped, 8-line, one-word-per-line cache between the
// LC-3b CPU port and physical memory. Reads are allocated on miss; writes are
// write-through with no write-allocate. Saturating read hit/miss counters.
module lc3b_word_cache (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic [15:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [1:0]  pmem_byte_enable,
    output logic [15:0] pmem_wdata,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  valid;
    logic [11:0] tag_arr  [8];
    logic [15:0] data_arr [8];

    logic [2:0]  index;
    logic [11:0] tag;
    logic        hit;
    logic [15:0] line_data;
    logic [15:0] merged_data;

    logic        fill_we;
    logic        write_we;
    logic        hit_inc;
    logic        miss_inc;

    assign index       = mem_address[3:1];
    assign tag         = mem_address[15:4];
    assign line_data   = data_arr[index];
    assign hit         = valid[index] && (tag_arr[index] == tag);
    assign merged_data = {mem_byte_enable[1] ? mem_wdata[15:8] : line_data[15:8],
                          mem_byte_enable[0] ? mem_wdata[7:0]  : line_data[7:0]};

    // Address/data passthroughs to physical memory; held at zero during reset.
    assign pmem_address     = reset ? '0 : {mem_address[15:1], 1'b0};
    assign pmem_byte_enable = reset ? '0 : mem_byte_enable;
    assign pmem_wdata       = reset ? '0 : mem_wdata;

    // State register; reset drops any outstanding physical request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake outputs and array/counter update strobes.
    always_comb begin
        state_next = state;
        mem_resp   = 1'b0;
        mem_rdata  = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        fill_we    = 1'b0;
        write_we   = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write) begin
                    state_next = WRITE;
                end else if (mem_read) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = line_data;
                        hit_inc   = 1'b1;
                    end else begin
                        state_next = FILL;
                        miss_inc   = 1'b1;
                    end
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_we    = 1'b1;
                    state_next = DONE;
                end
            end
            WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    write_we   = hit;
                    state_next = DONE;
                end
            end
            DONE: begin
                mem_resp   = 1'b1;
                mem_rdata  = line_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid bits and saturating counters; the only resettable line state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (fill_we) begin
                valid[index] <= 1'b1;
            end
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

    // Tag and data arrays; contents are qualified by valid so need no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_arr[index]  <= tag;
            data_arr[index] <= pmem_rdata;
        end else if (write_we) begin
            data_arr[index] <= merged_data;
        end
    end

endmodule

// File: tb/tb_lc3b_word_cache.sv
// tb_lc3b_word_cache: directed vectors for lc3b_word_cache with hand-computed
// expectations for misses, hits, byte-masked writes, aborts and saturation.
module tb_lc3b_word_cache;

    logic        clk;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int total;
    int bad;
    int exp_hit;
    int exp_miss;

    lc3b_word_cache dut (
        .clk              (clk),
        .reset            (reset),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_resp         (mem_resp),
        .pmem_address     (pmem_address),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_wdata       (pmem_wdata),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read that misses, fills after lat cycles of FILL, completes in DONE.
    task automatic do_miss(input string nm, input logic [15:0] addr, input int lat,
                           input logic [15:0] data);
        mem_address = addr;
        mem_read    = 1'b1;
        #1;
        chk({nm, "_idle_resp"}, mem_resp, 0);
        chk({nm, "_idle_pread"}, pmem_read, 0);
        step();
        exp_miss++;
        chk({nm, "_miss_cnt"}, miss_count, exp_miss);
        for (int i = 0; i < lat; i++) begin
            chk({nm, "_fill_pread"}, pmem_read, 1);
            chk({nm, "_fill_resp"}, mem_resp, 0);
            chk({nm, "_fill_paddr"}, pmem_address, {addr[15:1], 1'b0});
            if (i == lat - 1) begin
                pmem_rdata = data;
                pmem_resp  = 1'b1;
            end
            step();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        chk({nm, "_done_resp"}, mem_resp, 1);
        chk({nm, "_done_rdata"}, mem_rdata, data);
        chk({nm, "_done_pread"}, pmem_read, 0);
        mem_read = 1'b0;
        step();
        chk({nm, "_after_resp"}, mem_resp, 0);
        chk({nm, "_after_rdata"}, mem_rdata, 0);
    endtask

    // Read that hits: response in the same cycle, no physical access.
    task automatic do_hit(input string nm, input logic [15:0] addr, input logic [15:0] data);
        mem_address = addr;
        mem_read    = 1'b1;
        #1;
        chk({nm, "_resp"}, mem_resp, 1);
        chk({nm, "_rdata"}, mem_rdata, data);
        chk({nm, "_pread"}, pmem_read, 0);
        step();
        exp_hit++;
        mem_read = 1'b0;
        #1;
        chk({nm, "_hit_cnt"}, hit_count, exp_hit);
        chk({nm, "_resp_low"}, mem_resp, 0);
    endtask

    // Write-through; chk_rd selects whether DONE data is checked.
    task automatic do_write(input string nm, input logic [15:0] addr, input logic [1:0] be,
                            input logic [15:0] wd, input int lat, input bit chk_rd,
                            input logic [15:0] exp_rd);
        mem_address     = addr;
        mem_write       = 1'b1;
        mem_byte_enable = be;
        mem_wdata       = wd;
        #1;
        chk({nm, "_idle_resp"}, mem_resp, 0);
        step();
        for (int i = 0; i < lat; i++) begin
            chk({nm, "_pwrite"}, pmem_write, 1);
            chk({nm, "_pread"}, pmem_read, 0);
            chk({nm, "_pbe"}, pmem_byte_enable, be);
            chk({nm, "_pwdata"}, pmem_wdata, wd);
            chk({nm, "_paddr"}, pmem_address, {addr[15:1], 1'b0});
            chk({nm, "_resp"}, mem_resp, 0);
            if (i == lat - 1) pmem_resp = 1'b1;
            step();
        end
        pmem_resp = 1'b0;
        #1;
        chk({nm, "_done_resp"}, mem_resp, 1);
        if (chk_rd) chk({nm, "_done_rdata"}, mem_rdata, exp_rd);
        chk({nm, "_done_pwrite"}, pmem_write, 0);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        step();
        chk({nm, "_miss_cnt"}, miss_count, exp_miss);
    endtask

    initial begin
        total = 0; bad = 0; exp_hit = 0; exp_miss = 0;
        reset = 1'b1;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        #1;
        chk("rst_resp", mem_resp, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_pread", pmem_read, 0);
        chk("rst_pwrite", pmem_write, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Cold read, 3-cycle fill, then hits (also via odd byte address)
        do_miss("cold", 16'h3002, 3, 16'hBEEF);
        do_hit("rehit", 16'h3002, 16'hBEEF);
        do_hit("oddhit", 16'h3003, 16'hBEEF);

        // Low-byte write hit merges into the line
        do_write("wlo", 16'h3002, 2'b01, 16'h1234, 2, 1'b1, 16'hBE34);
        do_hit("merged", 16'h3002, 16'hBE34);

        // Read+write together: write wins; write miss leaves line invalid
        mem_read = 1'b1;
        do_write("wmiss", 16'h5006, 2'b11, 16'hA5A5, 1, 1'b0, 16'h0000);
        do_miss("after_wmiss", 16'h5006, 1, 16'h1111);

        // Conflict on index 1 evicts and re-misses
        do_miss("conflict", 16'h4002, 1, 16'hCAFE);
        do_hit("conflict_hit", 16'h4002, 16'hCAFE);
        do_miss("evicted", 16'h3002, 2, 16'hBE34);

        // Reset mid-FILL aborts immediately
        mem_address = 16'h4002;
        mem_read    = 1'b1;
        step();
        exp_miss++;
        chk("abort_pread_before", pmem_read, 1);
        #2;
        reset = 1'b1;
        #1;
        exp_hit = 0;
        exp_miss = 0;
        chk("abort_pread", pmem_read, 0);
        chk("abort_resp", mem_resp, 0);
        chk("abort_hits", hit_count, 0);
        chk("abort_misses", miss_count, 0);
        chk("abort_paddr", pmem_address, 0);
        pmem_rdata = 16'h9999;
        pmem_resp  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("abort_resp_hold", mem_resp, 0);
            chk("abort_pread_hold", pmem_read, 0);
        end
        @(negedge clk);
        reset      = 1'b0;
        mem_read   = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        step();

        // Stray pmem_resp in IDLE is ignored
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        #1;
        chk("stray_resp", mem_resp, 0);
        chk("stray_pread", pmem_read, 0);
        do_miss("post_abort", 16'h4002, 2, 16'hDDDD);

        // Hit counter saturation
        mem_address = 16'h4002;
        mem_read    = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        chk("sat_fffe", hit_count, 16'hFFFE);
        step();
        chk("sat_ffff", hit_count, 16'hFFFF);
        step();
        chk("sat_hold", hit_count, 16'hFFFF);
        chk("sat_resp", mem_resp, 1);
        chk("sat_rdata", mem_rdata, 16'hDDDD);
        mem_read = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
